cycle_counter_bank: RTL
=======================

Name: cycle_counter_bank

Overview:
- Parametrised multi-channel successor to the single cycle counter. NCH independent CNT_W-bit event counters, each with a per-event latched number and a ready pulse.
- Byte-wide register read port with atomic snapshot-on-read, and a write port for per-channel clear.
- Sits beside the timing/TDC blocks and supplies cycle/spill/trigger numbers to the readout path and the local bus.

Parameters:
- NCH, 4, number of channels (1..8)
- CNT_W, 18, counter width in bits (8..32)
- BASE_ADDR, 12, bus address of channel 0 byte 0
- MODE_EDGE, 0, per-channel bit mask (NCH bits); 1 = count rising edges of evt, 0 = count every clock evt is high

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk
- evt  in  NCH  event inputs, one per channel, synchronous to clk
- ready  out  NCH  one-clock pulse per channel when evtnum is updated
- evtnum  out  NCH*CNT_W  latched count, channel c at [c*CNT_W +: CNT_W]
- addr  in  8  bus address
- read  in  1  read strobe, level; action on rising edge
- write  in  1  write strobe, level; action on rising edge
- wdata  in  8  write data
- rdata  out  8  read data, registered

Behaviour:
- NB = ceil(CNT_W/8) bytes per channel. Channel c byte b is at address BASE_ADDR + c*NB + b, little-endian. Control/status address CSR = BASE_ADDR + NCH*NB. Address arithmetic is done in 8 bits; the parameters must keep CSR ≤ 255.
- Reset (reset==0 at posedge): all counters, evtnum, snapshots, ready, rdata, read/write delay regs and the edge-detect history go to 0.
- Count qualifier q[c]:
  - MODE_EDGE[c]=1: q[c] = evt[c] & ~evt_d[c].
  - MODE_EDGE[c]=0: q[c] = evt[c].
- On q[c]:
  - evtnum[c] <= cnt[c], i.e. the value before increment.
  - cnt[c] <= cnt[c]+1, mod 2^CNT_W; it wraps from all-ones to 0.
  - ready[c] <= 1 for exactly one clock. ready is registered, so it pulses the cycle after q.
- Clear: rising edge of write (write & ~write_d) with addr==CSR. For each c with wdata[c]==1, cnt[c] <= 0.
  - If clear and q[c] occur in the same clock: clear wins, so cnt[c]=0. evtnum[c] still latches the pre-clear value and ready[c] still pulses.
  - Writes to any other address are ignored.
- Snapshot: rising edge of read (read & ~read_d) with addr == byte 0 of channel c. snap[c] <= cnt[c], taking the value before any increment in that clock. Reads of bytes 1..NB-1 never re-snapshot, so a multi-byte read is atomic.
- rdata updates every clock, with 1-clock latency from addr:
  - Channel byte address: rdata <= snap[c] byte b.
  - Byte 0 in the clock its snapshot is taken: rdata <= the new snapshot byte 0 (bypass), so the first byte read is already coherent.
  - Unused high bits of the top byte read as 0.
  - addr==CSR: rdata <= status (see Optional Feature).
  - Any other address: rdata holds its previous value.
- A read held high over several clocks produces exactly one snapshot. read and write are independent and may be high together.
- Reset mid-operation overrides everything in that clock: a snapshot or clear pending in the same clock is discarded.

Optional Feature:
- Macro: CYCLECNT_OVF_FLAG_EN
- Defined: a sticky ovf[c] is set when cnt[c] wraps from all-ones to 0 on q[c]. CSR reads return {0.., ovf[NCH-1:0]}. A clear of channel c also clears ovf[c]. If a wrap and a clear of the same channel occur in the same clock, the clear wins and ovf[c]=0. Reset clears all ovf bits.
- Not defined: no ovf storage, the counter wraps silently, and CSR reads return 8'h00.

Test Plan:
- Reset low 2 clocks with evt=4'hF: all outputs 0. After reset rises, evt[0] high 5 clocks (MODE_EDGE=0) → ready[0] pulses 5 times, evtnum[0] ends at 4, cnt[0]=5.
- MODE_EDGE=4'b0010, evt[1] held high 10 clocks then low → exactly one ready[1] pulse, evtnum[1]=0. A second rising edge → evtnum[1]=1.
- Channel 2 cnt=0x2A5C3 (CNT_W=18, NB=3): read rising at addr 12+6=18 while evt[2] pulses in the same clock → rdata=0xC3 next clock, then addr 19 → 0xA5, addr 20 → 0x02. Byte 0 re-read with read held high does not re-snapshot (0xC3 stays).
- Write addr CSR=24, wdata=8'h05, with q[0] in the same clock → cnt[0]=0, cnt[2]=0, cnt[1] and cnt[3] unchanged, evtnum[0] = old count, ready[0] pulses.
- Preload channel 3 to 0x3FFFF, one event → cnt[3]=0, evtnum[3]=0x3FFFF. With CYCLECNT_OVF_FLAG_EN, CSR read → 8'h08; without it → 8'h00.
- Read at unmapped addr 200 after a read of addr 12 → rdata holds the addr-12 byte. Reset asserted mid-sequence → rdata=0 next clock.

Source files
------------

// File: rtl/cycle_counter_bank.sv
// cycle_counter_bank
//   NCH independent CNT_W-bit event counters. Each qualified event latches the
//   pre-increment count into evtnum, bumps the counter and pulses ready for one
//   clock. A byte-wide register port gives atomic snapshot-on-read of each
//   counter plus a control/status register used for per-channel clear.
//
//   Optional: define CYCLECNT_OVF_FLAG_EN to keep a sticky per-channel overflow
//   flag, readable at the CSR address; otherwise the CSR reads as 8'h00.
//
// Ports:
//   clk     system clock, posedge
//   reset   synchronous, active-low
//   evt     [NCH]        per-channel event inputs
//   ready   [NCH]        one-clock pulse when evtnum of a channel updates
//   evtnum  [NCH*CNT_W]  latched counts, channel c at [c*CNT_W +: CNT_W]
//   addr    [8]          bus address
//   read    read strobe (level, acts on rising edge)
//   write   write strobe (level, acts on rising edge)
//   wdata   [8]          write data (CSR: per-channel clear mask)
//   rdata   [8]          registered read data
module cycle_counter_bank #(
  parameter int unsigned      NCH       = 4,
  parameter int unsigned      CNT_W     = 18,
  parameter int unsigned      BASE_ADDR = 12,
  parameter logic [NCH-1:0]   MODE_EDGE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       evt,
  output logic [NCH-1:0]       ready,
  output logic [NCH*CNT_W-1:0] evtnum,
  input  logic [7:0]           addr,
  input  logic                 read,
  input  logic                 write,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  localparam int unsigned NB       = (CNT_W + 7) / 8;
  localparam logic [7:0]  CSR_ADDR = 8'(BASE_ADDR + NCH * NB);

  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CNT_W-1:0] evtnum_q, evtnum_d;
  logic [NCH-1:0][CNT_W-1:0] snap_q, snap_d;
  logic [NCH-1:0]            ready_q, ready_d;
  logic [NCH-1:0]            evt_d_q, evt_d_d;
  logic                      read_d_q, read_d_d;
  logic                      write_d_q, write_d_d;
  logic [7:0]                rdata_q, rdata_d;
`ifdef CYCLECNT_OVF_FLAG_EN
  logic [NCH-1:0]            ovf_q, ovf_d;
`endif

  logic [NCH-1:0]            qual;
  logic                      rd_rise;
  logic                      wr_rise;
  logic                      clr;
  logic [8*NB-1:0]           word;
  logic [7:0]                status;
  logic                      unused_wdata;

  // Level-mode channels mask out the history bit, so they count every high clock.
  assign qual         = evt & ~(evt_d_q & MODE_EDGE);
  assign rd_rise      = read & ~read_d_q;
  assign wr_rise      = write & ~write_d_q;
  assign clr          = wr_rise && (addr == CSR_ADDR);
  assign unused_wdata = ^wdata;

  assign ready  = ready_q;
  assign evtnum = evtnum_q;
  assign rdata  = rdata_q;

  always_comb begin
    cnt_d     = cnt_q;
    evtnum_d  = evtnum_q;
    snap_d    = snap_q;
    ready_d   = '0;
    evt_d_d   = evt;
    read_d_d  = read;
    write_d_d = write;
    rdata_d   = rdata_q;
    word      = '0;
    status    = '0;
`ifdef CYCLECNT_OVF_FLAG_EN
    ovf_d     = ovf_q;
    status[NCH-1:0] = ovf_q;
`endif

    for (int unsigned c = 0; c < NCH; c++) begin
      if (qual[c]) begin
        evtnum_d[c] = cnt_q[c];
        ready_d[c]  = 1'b1;
        cnt_d[c]    = cnt_q[c] + CNT_W'(1);
`ifdef CYCLECNT_OVF_FLAG_EN
        if (&cnt_q[c]) ovf_d[c] = 1'b1;
`endif
      end
      if (rd_rise && (addr == 8'(BASE_ADDR + c * NB))) begin
        snap_d[c] = cnt_q[c];
      end
      // Clear is applied after the increment so it wins over a same-clock event.
      if (clr && wdata[c]) begin
        cnt_d[c] = '0;
`ifdef CYCLECNT_OVF_FLAG_EN
        ovf_d[c] = 1'b0;
`endif
      end
    end

    // Reading from snap_d gives the byte-0 bypass in the snapshot clock.
    for (int unsigned c = 0; c < NCH; c++) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (addr == 8'(BASE_ADDR + c * NB + b)) begin
          word            = '0;
          word[CNT_W-1:0] = snap_d[c];
          rdata_d         = word[b*8 +: 8];
        end
      end
    end
    if (addr == CSR_ADDR) begin
      rdata_d = status;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      evtnum_q  <= '0;
      snap_q    <= '0;
      ready_q   <= '0;
      evt_d_q   <= '0;
      read_d_q  <= 1'b0;
      write_d_q <= 1'b0;
      rdata_q   <= '0;
`ifdef CYCLECNT_OVF_FLAG_EN
      ovf_q     <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      evtnum_q  <= evtnum_d;
      snap_q    <= snap_d;
      ready_q   <= ready_d;
      evt_d_q   <= evt_d_d;
      read_d_q  <= read_d_d;
      write_d_q <= write_d_d;
      rdata_q   <= rdata_d;
`ifdef CYCLECNT_OVF_FLAG_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

endmodule
